// File: rtl/pixel_sched_pkg.sv
// Shared types and default sizes for the pixel SRAM port-A phase scheduler.
package pixel_sched_pkg;

    localparam int unsigned DEF_ADDR_W     = 16;
    localparam int unsigned DEF_DATA_W     = 8;
    localparam int unsigned DEF_NUM_PIXELS = 65536;
    localparam int unsigned DEF_STARVE_MAX = 4;

    typedef enum logic [1:0] {
        PH_LOAD   = 2'd0,
        PH_WAIT   = 2'd1,
        PH_PROC   = 2'd2,
        PH_UNLOAD = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        OWN_NONE = 3'd0,
        OWN_RX   = 3'd1,
        OWN_ENG  = 3'd2,
        OWN_TX   = 3'd3,
        OWN_DBG  = 3'd4
    } mem_owner_e;

endpackage

// File: rtl/pixel_port_arb.sv
// Port-A owner select: phase owner vs. debug reader with bounded starvation.
// Debug arbitration only exists when PIXEL_SCHED_DBG_EN is defined.
module pixel_port_arb
    import pixel_sched_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  phase_e     phase,
    input  logic       rx_valid,
    input  logic       eng_req,
    input  logic       tx_rd_req,
    input  logic       dbg_req,
    output mem_owner_e owner
);

`ifdef PIXEL_SCHED_DBG_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             forced;

    assign forced = dbg_req && (starve_cnt == CNT_W'(STARVE_MAX));

    // rx writes are real-time, so a forced debug grant waits for an idle rx cycle
    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            case (phase)
                PH_LOAD: begin
                    if (rx_valid)     owner = OWN_RX;
                    else if (dbg_req) owner = OWN_DBG;
                end
                PH_PROC: begin
                    if (forced)       owner = OWN_DBG;
                    else if (eng_req) owner = OWN_ENG;
                    else if (dbg_req) owner = OWN_DBG;
                end
                PH_UNLOAD: begin
                    if (forced)         owner = OWN_DBG;
                    else if (tx_rd_req) owner = OWN_TX;
                    else if (dbg_req)   owner = OWN_DBG;
                end
                default: begin
                    if (dbg_req) owner = OWN_DBG;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!dbg_req || owner == OWN_DBG) begin
            starve_cnt <= '0;
        end else if (starve_cnt != CNT_W'(STARVE_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_dbg;
    assign unused_dbg = ^{clk, dbg_req};

    always_comb begin
        owner = OWN_NONE;
        if (!rst) begin
            case (phase)
                PH_LOAD:   if (rx_valid)  owner = OWN_RX;
                PH_PROC:   if (eng_req)   owner = OWN_ENG;
                PH_UNLOAD: if (tx_rd_req) owner = OWN_TX;
                default:   owner = OWN_NONE;
            endcase
        end
    end
`endif

endmodule

// File: rtl/pixel_mem_sched.sv
// Frame phase scheduler (LOAD/WAIT/PROCESS/UNLOAD) and port-A mux for mem_block.
// Define PIXEL_SCHED_DBG_EN to enable the starvation-bounded debug read port.
module pixel_mem_sched
    import pixel_sched_pkg::*;
#(
    parameter int unsigned ADDR_W     = DEF_ADDR_W,
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned NUM_PIXELS = DEF_NUM_PIXELS,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              MAX10_CLK1_50,
    input  logic              rst,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_req,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    input  logic              dith_start,
    input  logic              eng_req,
    input  logic              eng_we,
    input  logic [ADDR_W-1:0] eng_addr,
    input  logic [DATA_W-1:0] eng_wdata,
    output logic              eng_gnt,
    output logic              eng_rvalid,
    output logic [DATA_W-1:0] eng_rdata,
    input  logic              eng_done,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        phase,
    output logic [7:0]        overrun_cnt
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

    phase_e            phase_q;
    phase_e            phase_d;
    mem_owner_e        owner;
    mem_owner_e        rd_owner;
    logic [ADDR_W-1:0] load_ptr;
    logic [ADDR_W-1:0] unload_ptr;
    logic              tx_pend;
    logic              consume_c;
    logic              tx_rd_req_c;
    logic [ADDR_W-1:0] tx_rd_addr_c;

    assign phase = phase_q;

    // A consume issues the next read in the same cycle; a lost grant leaves it pending
    assign consume_c    = (phase_q == PH_UNLOAD) && tx_valid && tx_req;
    assign tx_rd_req_c  = (phase_q == PH_UNLOAD) &&
                          (tx_pend || (consume_c && unload_ptr != LAST_ADDR));
    assign tx_rd_addr_c = consume_c ? unload_ptr + ADDR_W'(1) : unload_ptr;

    pixel_port_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk       (MAX10_CLK1_50),
        .rst       (rst),
        .phase     (phase_q),
        .rx_valid  (rx_valid),
        .eng_req   (eng_req),
        .tx_rd_req (tx_rd_req_c),
        .dbg_req   (dbg_req),
        .owner     (owner)
    );

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_LOAD:   if (rx_valid && load_ptr == LAST_ADDR)    phase_d = PH_WAIT;
            PH_WAIT:   if (dith_start)                           phase_d = PH_PROC;
            PH_PROC:   if (eng_done)                             phase_d = PH_UNLOAD;
            PH_UNLOAD: if (consume_c && unload_ptr == LAST_ADDR) phase_d = PH_LOAD;
            default:   phase_d = PH_LOAD;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        eng_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        case (owner)
            OWN_RX: begin
                mem_addr  = load_ptr;
                mem_wdata = rx_data;
                mem_we    = 1'b1;
            end
            OWN_ENG: begin
                mem_addr  = eng_addr;
                mem_wdata = eng_wdata;
                mem_we    = eng_we;
                mem_re    = !eng_we;
                eng_gnt   = 1'b1;
            end
            OWN_TX: begin
                mem_addr = tx_rd_addr_c;
                mem_re   = 1'b1;
            end
`ifdef PIXEL_SCHED_DBG_EN
            OWN_DBG: begin
                mem_addr = dbg_addr;
                mem_re   = 1'b1;
                dbg_gnt  = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge MAX10_CLK1_50) begin
        if (rst) begin
            phase_q     <= PH_LOAD;
            rd_owner    <= OWN_NONE;
            load_ptr    <= '0;
            unload_ptr  <= '0;
            tx_pend     <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            overrun_cnt <= '0;
        end else begin
            phase_q  <= phase_d;
            rd_owner <= mem_re ? owner : OWN_NONE;

            if (owner == OWN_RX) begin
                load_ptr <= (load_ptr == LAST_ADDR) ? '0 : load_ptr + ADDR_W'(1);
            end

            if (rx_valid && phase_q != PH_LOAD && overrun_cnt != 8'hFF) begin
                overrun_cnt <= overrun_cnt + 8'd1;
            end

            if (phase_q == PH_PROC && eng_done) begin
                tx_pend    <= 1'b1;
                unload_ptr <= '0;
            end else begin
                tx_pend <= tx_rd_req_c && (owner != OWN_TX);
            end

            if (consume_c) begin
                tx_valid   <= 1'b0;
                unload_ptr <= (unload_ptr == LAST_ADDR) ? '0 : unload_ptr + ADDR_W'(1);
            end else if (rd_owner == OWN_TX) begin
                tx_valid <= 1'b1;
                tx_data  <= mem_rdata;
            end
        end
    end

    // Read data is only presented in the cycle it returns from the SRAM
    assign eng_rvalid = (rd_owner == OWN_ENG);
    assign eng_rdata  = eng_rvalid ? mem_rdata : '0;

`ifdef PIXEL_SCHED_DBG_EN
    assign dbg_rvalid = (rd_owner == OWN_DBG);
    assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;
`else
    logic unused_dbg_addr;
    assign unused_dbg_addr = ^dbg_addr;
    assign dbg_rvalid      = 1'b0;
    assign dbg_rdata       = '0;
`endif

endmodule

// File: tb/tb_pixel_mem_sched.sv
// Scoreboard bench for pixel_mem_sched with a 16-pixel frame and a 1-cycle SRAM model.
`timescale 1ns/1ps
module tb_pixel_mem_sched;

    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_PIXELS = 16;
    localparam int unsigned STARVE_MAX = 4;
`ifdef PIXEL_SCHED_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              tx_req;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              dith_start;
    logic              eng_req;
    logic              eng_we;
    logic [ADDR_W-1:0] eng_addr;
    logic [DATA_W-1:0] eng_wdata;
    logic              eng_gnt;
    logic              eng_rvalid;
    logic [DATA_W-1:0] eng_rdata;
    logic              eng_done;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        phase;
    logic [7:0]        overrun_cnt;

    logic [DATA_W-1:0] sram  [0:NUM_PIXELS-1];
    logic [DATA_W-1:0] model [0:NUM_PIXELS-1];

    logic [ADDR_W+DATA_W-1:0] wr_q [$];
    logic [DATA_W-1:0]        tx_q [$];
    logic [DATA_W-1:0]        eng_q [$];
    logic [DATA_W-1:0]        dbg_q [$];

    int total = 0;
    int bad   = 0;

    pixel_mem_sched #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .NUM_PIXELS (NUM_PIXELS),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .MAX10_CLK1_50 (clk),
        .rst           (rst),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .tx_req        (tx_req),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .dith_start    (dith_start),
        .eng_req       (eng_req),
        .eng_we        (eng_we),
        .eng_addr      (eng_addr),
        .eng_wdata     (eng_wdata),
        .eng_gnt       (eng_gnt),
        .eng_rvalid    (eng_rvalid),
        .eng_rdata     (eng_rdata),
        .eng_done      (eng_done),
        .dbg_req       (dbg_req),
        .dbg_addr      (dbg_addr),
        .dbg_gnt       (dbg_gnt),
        .dbg_rvalid    (dbg_rvalid),
        .dbg_rdata     (dbg_rdata),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_we        (mem_we),
        .mem_re        (mem_re),
        .mem_rdata     (mem_rdata),
        .phase         (phase),
        .overrun_cnt   (overrun_cnt)
    );

    always #5 clk = ~clk;

    // Synchronous SRAM with 1-cycle read latency
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr[3:0]] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr[3:0]];
    end

    task automatic test_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_data = '0; tx_req = 1'b0;
        dith_start = 1'b0; eng_req = 1'b0; eng_we = 1'b0; eng_addr = '0;
        eng_wdata = '0; eng_done = 1'b0; dbg_req = 1'b0; dbg_addr = '0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (phase !== 2'd0) begin bad++; $display("FAIL reset_phase got=%0d exp=0", phase); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset_tx_valid got=%b exp=0", tx_valid); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
        total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL reset_overrun got=%0d exp=0", overrun_cnt); end
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL reset_mem_en got=%b exp=00", {mem_we, mem_re}); end
        total++; if (mem_addr !== 16'd0) begin bad++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        total++; if ({eng_gnt, eng_rvalid, dbg_gnt, dbg_rvalid} !== 4'b0000) begin
            bad++; $display("FAIL reset_handshakes got=%b exp=0000", {eng_gnt, eng_rvalid, dbg_gnt, dbg_rvalid});
        end
        rst = 1'b0;
    endtask

    task automatic test_load(input logic [7:0] base, input int n, input logic [1:0] exp_phase);
        logic [ADDR_W+DATA_W-1:0] exp;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = base + 8'(i);
            model[i] = base + 8'(i);
            wr_q.push_back({16'(i), base + 8'(i)});
            #1;
            exp = wr_q.pop_front();
            total++;
            if (mem_we !== 1'b1 || {mem_addr, mem_wdata} !== exp) begin
                bad++; $display("FAIL load_write[%0d] got we=%b addr/data=%h exp addr/data=%h", i, mem_we, {mem_addr, mem_wdata}, exp);
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        total++; if (phase !== exp_phase) begin bad++; $display("FAIL load_end_phase got=%0d exp=%0d", phase, exp_phase); end
    endtask

    task automatic test_drop();
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = 8'h77;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL drop_no_write got=%b exp=0", mem_we); end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        total++; if (overrun_cnt !== 8'd1) begin bad++; $display("FAIL drop_overrun got=%0d exp=1", overrun_cnt); end
        total++; if (phase !== 2'd1) begin bad++; $display("FAIL drop_phase got=%0d exp=1", phase); end
    endtask

    task automatic start_proc();
        @(negedge clk);
        dith_start = 1'b1;
        @(negedge clk);
        dith_start = 1'b0;
        #1;
        total++; if (phase !== 2'd2) begin bad++; $display("FAIL proc_entry_phase got=%0d exp=2", phase); end
    endtask

    task automatic test_proc_starve();
        bit          op_we   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  op_addr [6] = '{4'd2, 4'd3, 4'd3, 4'd9, 4'd14, 4'd14};
        logic [7:0]  op_wd   [6] = '{8'h00, 8'hA3, 8'h00, 8'h00, 8'h5E, 8'h00};
        logic [7:0]  e;
        bit          exp_dbg;
        int          j = 0;
        int          k = 0;
        while (j < 6 && k < 20) begin
            @(negedge clk);
            eng_req   = 1'b1;
            eng_we    = op_we[j];
            eng_addr  = 16'(op_addr[j]);
            eng_wdata = op_wd[j];
            dbg_req   = (k <= int'(STARVE_MAX));
            dbg_addr  = 16'd5;
            exp_dbg   = DBG_EN && (k == int'(STARVE_MAX));
            #1;
            total++;
            if (eng_rvalid !== (eng_q.size() != 0)) begin
                bad++; $display("FAIL eng_rvalid[%0d] got=%b exp=%b", k, eng_rvalid, eng_q.size() != 0);
            end
            if (eng_q.size() != 0) begin
                e = eng_q.pop_front();
                total++; if (eng_rdata !== e) begin bad++; $display("FAIL eng_rdata[%0d] got=%h exp=%h", k, eng_rdata, e); end
            end
            total++;
            if (dbg_rvalid !== (dbg_q.size() != 0)) begin
                bad++; $display("FAIL dbg_rvalid[%0d] got=%b exp=%b", k, dbg_rvalid, dbg_q.size() != 0);
            end
            if (dbg_q.size() != 0) begin
                e = dbg_q.pop_front();
                total++; if (dbg_rdata !== e) begin bad++; $display("FAIL dbg_rdata[%0d] got=%h exp=%h", k, dbg_rdata, e); end
            end
            total++; if (dbg_gnt !== exp_dbg) begin bad++; $display("FAIL dbg_gnt[%0d] got=%b exp=%b", k, dbg_gnt, exp_dbg); end
            total++; if (eng_gnt !== !exp_dbg) begin bad++; $display("FAIL eng_gnt[%0d] got=%b exp=%b", k, eng_gnt, !exp_dbg); end
            if (exp_dbg) begin
                dbg_q.push_back(model[5]);
            end else begin
                if (op_we[j]) model[op_addr[j]] = op_wd[j];
                else          eng_q.push_back(model[op_addr[j]]);
                j++;
            end
            k++;
        end
        @(negedge clk);
        eng_req = 1'b0;
        dbg_req = 1'b0;
        #1;
        total++;
        if (eng_rvalid !== 1'b1 || eng_q.size() != 1) begin
            bad++; $display("FAIL eng_last_rvalid got=%b exp=1 (pending=%0d)", eng_rvalid, eng_q.size());
        end else begin
            e = eng_q.pop_front();
            total++; if (eng_rdata !== e) begin bad++; $display("FAIL eng_last_rdata got=%h exp=%h", eng_rdata, e); end
        end
        total++; if (dbg_q.size() != 0) begin bad++; $display("FAIL dbg_return_missing pending=%0d exp=0", dbg_q.size()); dbg_q.delete(); end
    endtask

    // Pulse eng_done, check entry latency, then consume stop_at bytes with tx_req held high
    task automatic run_unload(input int stop_at);
        logic [7:0] e;
        int         n   = 0;
        int         gap = 0;
        int         cyc = 0;
        tx_q.delete();
        for (int i = 0; i < int'(NUM_PIXELS); i++) tx_q.push_back(model[i]);
        @(negedge clk);
        eng_done = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        #1;
        total++; if (phase !== 2'd3) begin bad++; $display("FAIL unload_entry_phase got=%0d exp=3", phase); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL unload_entry_tx_valid got=%b exp=0", tx_valid); end
        @(negedge clk);
        #1;
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL unload_early_tx_valid got=%b exp=0", tx_valid); end
        @(negedge clk);
        #1;
        total++; if (tx_valid !== 1'b1) begin bad++; $display("FAIL unload_first_tx_valid got=%b exp=1", tx_valid); end
        tx_req = 1'b1;
        while (n < stop_at && cyc < 200) begin
            if (tx_valid) begin
                e = tx_q.pop_front();
                total++; if (tx_data !== e) begin bad++; $display("FAIL tx_data[%0d] got=%h exp=%h", n, tx_data, e); end
                if (n > 0) begin
                    total++; if (gap != 2) begin bad++; $display("FAIL tx_latency[%0d] got=%0d exp=2", n, gap); end
                end
                n++;
                gap = 0;
            end
            @(negedge clk);
            #1;
            gap++;
            cyc++;
        end
        tx_req = 1'b0;
        total++; if (n != stop_at) begin bad++; $display("FAIL unload_timeout got=%0d bytes exp=%0d", n, stop_at); end
    endtask

    task automatic test_unload_full();
        run_unload(int'(NUM_PIXELS));
        total++; if (phase !== 2'd0) begin bad++; $display("FAIL unload_done_phase got=%0d exp=0", phase); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL unload_done_tx_valid got=%b exp=0", tx_valid); end
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        test_load(8'h20, int'(NUM_PIXELS), 2'd1);
        start_proc();
        run_unload(7);
        while (tx_valid !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        total++; if (tx_data !== model[7]) begin bad++; $display("FAIL mid_tx_data7 got=%h exp=%h", tx_data, model[7]); end
        rst = 1'b1;
        #1;
        total++; if ({mem_we, mem_re} !== 2'b00) begin bad++; $display("FAIL mid_rst_mem_en got=%b exp=00", {mem_we, mem_re}); end
        @(negedge clk);
        #1;
        total++; if (phase !== 2'd0) begin bad++; $display("FAIL mid_rst_phase got=%0d exp=0", phase); end
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_tx_valid got=%b exp=0", tx_valid); end
        total++; if (overrun_cnt !== 8'd0) begin bad++; $display("FAIL mid_rst_overrun got=%0d exp=0", overrun_cnt); end
        rst = 1'b0;
        test_load(8'h40, 3, 2'd0);
    endtask

    initial begin
        test_reset();
        test_load(8'h00, int'(NUM_PIXELS), 2'd1);
        test_drop();
        start_proc();
        test_proc_starve();
        test_unload_full();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
